// File: rtl/trace_commit_monitor.sv
// Commit trace monitor: counts cycles/instructions, serializes WB/MEM/halt events
// into a trace FIFO drained by a valid/ready consumer, and stops on halt or watchdog.
module trace_commit_monitor #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 100000,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         trace_en,
    input  logic [ADDR_W-1:0]            pc,
    input  logic                         reg_we,
    input  logic [REG_W-1:0]             reg_idx,
    input  logic [DATA_W-1:0]            reg_data,
    input  logic                         mem_re,
    input  logic                         mem_we,
    input  logic [ADDR_W-1:0]            mem_addr,
    input  logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         hlt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2+ADDR_W+DATA_W-1:0]   out_entry,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [CNT_W-1:0]             inst_count,
    output logic [CNT_W-1:0]             drop_count,
    output logic                         overflow,
    output logic                         halted,
    output logic                         timeout,
    output logic                         done
);

    localparam int ENTRY_W = 2 + ADDR_W + DATA_W;
    localparam int PTR_W   = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, TIMEOUT = 2'd2} stateT;
    stateT state, stateNext;

    logic [ENTRY_W-1:0] fifoMem [DEPTH];
    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [PTR_W:0]     occ, freeSlots;
    logic [ENTRY_W-1:0] evEntry [4];
    logic [ENTRY_W-1:0] wrEntry [4];
    logic [3:0]         evValid;
    logic [2:0]         evCount, wrCount, dropN;
    logic [CNT_W:0]     dropSum;
    logic               capture, commit, pop;

    // Handshake: the head entry transfers on a rising edge where out_valid and
    // out_ready are both high; out_entry holds steady while out_valid & !out_ready.
    assign out_valid = (occ != '0);
    assign out_entry = fifoMem[rdPtr];
    assign pop       = out_valid & out_ready;
    assign commit    = hlt | reg_we | mem_we;
    assign halted    = (state == HALTED);
    assign timeout   = (state == TIMEOUT);
    assign done      = (halted | timeout) & (occ == '0);

    always_comb begin
        capture    = (state == RUN) && trace_en;
        evValid    = {capture && hlt, capture && mem_we, capture && mem_re, capture && reg_we};
        evEntry[0] = {2'b00, ADDR_W'(reg_idx), reg_data};
        evEntry[1] = {2'b01, mem_addr, mem_rdata};
        evEntry[2] = {2'b10, mem_addr, mem_wdata};
        evEntry[3] = {2'b11, pc, DATA_W'(0)};
        evCount    = 3'(evValid[0]) + 3'(evValid[1]) + 3'(evValid[2]) + 3'(evValid[3]);
        freeSlots  = (PTR_W+1)'(DEPTH) - occ;
        wrCount    = 3'd0;
        for (int i = 0; i < 4; i++) wrEntry[i] = '0;
        // All-or-nothing per cycle; a lone HALT still gets in if any slot is free.
        if ((PTR_W+1)'(evCount) <= freeSlots) begin
            for (int i = 0; i < 4; i++) begin
                if (evValid[i]) begin
                    wrEntry[wrCount[1:0]] = evEntry[i];
                    wrCount = wrCount + 3'd1;
                end
            end
        end else if (evValid[3] && (freeSlots != '0)) begin
            wrEntry[0] = evEntry[3];
            wrCount    = 3'd1;
        end
        dropN   = evCount - wrCount;
        dropSum = {1'b0, drop_count} + (CNT_W+1)'(dropN);
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            RUN: begin
                if (hlt)
                    stateNext = HALTED;
                else if (cycle_count == CNT_W'(MAX_CYCLES - 1))
                    stateNext = TIMEOUT;
            end
            default: stateNext = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < wrCount) fifoMem[wrPtr + PTR_W'(i)] <= wrEntry[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wrPtr       <= '0;
            rdPtr       <= '0;
            occ         <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            state <= stateNext;
            wrPtr <= wrPtr + PTR_W'(wrCount);
            rdPtr <= rdPtr + PTR_W'(pop);
            occ   <= occ + (PTR_W+1)'(wrCount) - (PTR_W+1)'(pop);
            if (state == RUN) begin
                if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
                if (commit) inst_count <= inst_count + 1'b1;
            end
            if (dropN != 3'd0) begin
                drop_count <= dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
                overflow   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_commit_monitor.sv
// Scoreboard bench for trace_commit_monitor: a small reference model pushes expected
// trace entries as events are driven; the head is compared whenever it is consumed.
module tb_trace_commit_monitor;

    localparam int DATA_W = 16, ADDR_W = 16, REG_W = 4, DEPTH = 16, MAXC = 20, CNT_W = 32;
    localparam int W = 2 + ADDR_W + DATA_W;

    logic clk = 1'b0, rst, trace_en, reg_we, mem_re, mem_we, hlt, out_ready;
    logic [ADDR_W-1:0] pc, mem_addr;
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] reg_data, mem_wdata, mem_rdata;
    logic              out_valid, overflow, halted, timeout, done;
    logic [W-1:0]      out_entry;
    logic [CNT_W-1:0]  cycle_count, inst_count, drop_count;

    logic [W-1:0] exp_q[$];
    int checks = 0, failures = 0;
    int mOcc, mCycle, mInst, mDrop, nPopped;
    bit mRun, mOvf;

    trace_commit_monitor #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .DEPTH(DEPTH),
                           .MAX_CYCLES(MAXC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .pc(pc), .reg_we(reg_we),
        .reg_idx(reg_idx), .reg_data(reg_data), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
        .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
        .cycle_count(cycle_count), .inst_count(inst_count), .drop_count(drop_count),
        .overflow(overflow), .halted(halted), .timeout(timeout), .done(done)
    );

    always #5 clk = ~clk;

    task automatic idle();
        reg_we = 0; mem_re = 0; mem_we = 0; hlt = 0;
        reg_idx = '0; reg_data = '0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0; pc = '0;
    endtask

    // One clock: check/consume the head, model this cycle's capture, advance.
    task automatic step();
        logic [W-1:0] cand[4];
        logic [W-1:0] expv;
        logic [3:0] v;
        bit popNow, te;
        int n, free, written;
        popNow = (mOcc != 0) && out_ready;
        checks++;
        if (out_valid !== (mOcc != 0)) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b", out_valid, mOcc != 0);
        end
        if (popNow) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL entry_pop: got %h with empty expected queue", out_entry);
            end else begin
                expv = exp_q.pop_front();
                if (out_entry !== expv) begin
                    failures++;
                    $display("FAIL entry: got %h expected %h", out_entry, expv);
                end
            end
            nPopped++;
        end
        te = mRun && trace_en;
        v = {te && hlt, te && mem_we, te && mem_re, te && reg_we};
        cand[0] = {2'b00, 12'h000, reg_idx, reg_data};
        cand[1] = {2'b01, mem_addr, mem_rdata};
        cand[2] = {2'b10, mem_addr, mem_wdata};
        cand[3] = {2'b11, pc, 16'h0000};
        n = $countones(v);
        free = DEPTH - mOcc;
        written = 0;
        if (n <= free) begin
            for (int i = 0; i < 4; i++) if (v[i]) begin exp_q.push_back(cand[i]); written++; end
        end else if (v[3] && free >= 1) begin
            exp_q.push_back(cand[3]);
            written = 1;
        end
        mDrop += n - written;
        if (n > written) mOvf = 1;
        mOcc = mOcc + written - (popNow ? 1 : 0);
        if (mRun) begin
            if (hlt || reg_we || mem_we) mInst++;
            if (hlt) mRun = 0;
            else if (mCycle == MAXC - 1) mRun = 0;
            mCycle++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        exp_q.delete();
        mOcc = 0; mCycle = 0; mInst = 0; mDrop = 0; nPopped = 0; mRun = 1; mOvf = 0;
    endtask

    task automatic drain();
        idle();
        out_ready = 1;
        for (int k = 0; k < 64 && mOcc != 0; k++) step();
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: out_valid=%b leftover_expected=%0d", out_valid, exp_q.size());
        end
    endtask

    task automatic test_reset();
        idle(); trace_en = 1; out_ready = 0;
        do_reset();
        checks++;
        if ({out_valid, overflow, halted, timeout, done} !== 5'b0 ||
            cycle_count !== 0 || inst_count !== 0 || drop_count !== 0) begin
            failures++;
            $display("FAIL reset_state: flags=%b cyc=%0d inst=%0d drop=%0d",
                     {out_valid, overflow, halted, timeout, done}, cycle_count, inst_count, drop_count);
        end
    endtask

    task automatic test_reg_stream();
        do_reset();
        trace_en = 1; out_ready = 1;
        reg_we = 1; reg_idx = 4'd3; reg_data = 16'h00AB;
        repeat (3) step();
        idle();
        checks++;
        if (inst_count !== 3 || cycle_count !== 3) begin
            failures++;
            $display("FAIL reg_stream_counts: inst=%0d cyc=%0d expected 3/3", inst_count, cycle_count);
        end
        drain();
        checks++;
        if (nPopped != 3) begin
            failures++;
            $display("FAIL reg_stream_pops: got %0d expected 3", nPopped);
        end
    endtask

    task automatic test_multi_event();
        do_reset();
        trace_en = 1; out_ready = 0;
        reg_we = 1; reg_idx = 4'd5; reg_data = 16'h5555;
        mem_re = 1; mem_we = 1; mem_addr = 16'h0040; mem_rdata = 16'h1111; mem_wdata = 16'h2222;
        hlt = 1; pc = 16'h0010;
        step();
        idle();
        checks++;
        if (inst_count !== 1 || halted !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL multi_event_state: inst=%0d halted=%b done=%b expected 1/1/0",
                     inst_count, halted, done);
        end
        drain();
        checks++;
        if (nPopped != 4 || done !== 1'b1) begin
            failures++;
            $display("FAIL multi_event_done: pops=%0d done=%b expected 4/1", nPopped, done);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        trace_en = 1; out_ready = 0;
        for (int i = 0; i < 17; i++) begin
            reg_we = 1; reg_idx = 4'(i); reg_data = 16'($urandom_range(0, 16'hFFFF));
            step();
        end
        mem_we = 1; mem_addr = 16'h0100; mem_wdata = 16'hBEEF;
        step();
        idle();
        checks++;
        if (drop_count !== 3 || overflow !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL overflow_counts: drop=%0d ovf=%b valid=%b expected 3/1/1",
                     drop_count, overflow, out_valid);
        end
        drain();
        checks++;
        if (nPopped != 16) begin
            failures++;
            $display("FAIL overflow_pops: got %0d expected 16", nPopped);
        end
    endtask

    task automatic test_halt_full();
        do_reset();
        trace_en = 1; out_ready = 0;
        for (int i = 0; i < 16; i++) begin
            reg_we = 1; reg_idx = 4'(i); reg_data = 16'(i * 7);
            step();
        end
        idle(); hlt = 1; pc = 16'h0ABC;
        step();
        idle();
        checks++;
        if (halted !== 1'b1 || drop_count !== 1 || overflow !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL halt_full_drop: halted=%b drop=%0d ovf=%b done=%b expected 1/1/1/0",
                     halted, drop_count, overflow, done);
        end
        drain();
        checks++;
        if (nPopped != 16 || done !== 1'b1) begin
            failures++;
            $display("FAIL halt_full_pops: pops=%0d done=%b expected 16/1", nPopped, done);
        end
    endtask

    task automatic test_halt_one_free();
        do_reset();
        trace_en = 1; out_ready = 0;
        for (int i = 0; i < 15; i++) begin
            reg_we = 1; reg_idx = 4'(i); reg_data = 16'(i + 16'h100);
            step();
        end
        reg_we = 1; reg_idx = 4'd9; reg_data = 16'h9999; hlt = 1; pc = 16'h0022;
        step();
        idle();
        checks++;
        if (halted !== 1'b1 || drop_count !== 1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL halt_one_free: halted=%b drop=%0d ovf=%b expected 1/1/1",
                     halted, drop_count, overflow);
        end
        drain();
        checks++;
        if (nPopped != 16) begin
            failures++;
            $display("FAIL halt_one_free_pops: got %0d expected 16", nPopped);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        trace_en = 1; out_ready = 1;
        idle();
        repeat (19) step();
        checks++;
        if (timeout !== 1'b0 || cycle_count !== 19) begin
            failures++;
            $display("FAIL timeout_early: timeout=%b cyc=%0d expected 0/19", timeout, cycle_count);
        end
        step();
        checks++;
        if (timeout !== 1'b1 || cycle_count !== 20 || done !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fire: timeout=%b cyc=%0d done=%b expected 1/20/1",
                     timeout, cycle_count, done);
        end
        reg_we = 1; reg_idx = 4'd2; reg_data = 16'h7777;
        repeat (3) step();
        idle();
        checks++;
        if (inst_count !== 0 || cycle_count !== 20 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_frozen: inst=%0d cyc=%0d valid=%b expected 0/20/0",
                     inst_count, cycle_count, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        trace_en = 1; out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            reg_we = 1; reg_idx = 4'(i); reg_data = 16'(i + 1);
            step();
        end
        idle(); out_ready = 1;
        step();
        do_reset();
        checks++;
        if ({out_valid, overflow, halted, timeout, done} !== 5'b0 ||
            cycle_count !== 0 || inst_count !== 0 || drop_count !== 0) begin
            failures++;
            $display("FAIL mid_reset: flags=%b cyc=%0d inst=%0d drop=%0d",
                     {out_valid, overflow, halted, timeout, done}, cycle_count, inst_count, drop_count);
        end
        trace_en = 0;
        for (int i = 0; i < 6; i++) begin
            reg_we = (i % 2 == 0); reg_idx = 4'd1; reg_data = 16'(i);
            step();
        end
        idle();
        checks++;
        if (inst_count !== 3 || out_valid !== 1'b0 || nPopped != 0) begin
            failures++;
            $display("FAIL trace_disabled: inst=%0d valid=%b pops=%0d expected 3/0/0",
                     inst_count, out_valid, nPopped);
        end
        trace_en = 1;
    endtask

    task automatic test_random();
        do_reset();
        trace_en = 1;
        for (int i = 0; i < 18; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            reg_we = 1'($urandom_range(0, 1)); reg_idx = 4'($urandom_range(0, 15));
            reg_data = 16'($urandom); mem_re = 1'($urandom_range(0, 1));
            mem_we = 1'($urandom_range(0, 1)); mem_addr = 16'($urandom);
            mem_wdata = 16'($urandom); mem_rdata = 16'($urandom);
            hlt = ($urandom_range(0, 15) == 0); pc = 16'($urandom);
            step();
        end
        idle();
        checks++;
        if (cycle_count !== CNT_W'(mCycle) || inst_count !== CNT_W'(mInst) ||
            drop_count !== CNT_W'(mDrop) || overflow !== mOvf || halted === timeout && !mRun) begin
            failures++;
            $display("FAIL random_counts: cyc=%0d/%0d inst=%0d/%0d drop=%0d/%0d ovf=%b/%b",
                     cycle_count, mCycle, inst_count, mInst, drop_count, mDrop, overflow, mOvf);
        end
        drain();
    endtask

    initial begin
        rst = 1; trace_en = 0; out_ready = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_reg_stream();
        test_multi_event();
        test_overflow();
        test_halt_full();
        test_halt_one_free();
        test_timeout();
        test_mid_reset();
        repeat (3) test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trace_commit_monitor.md
Name: trace_commit_monitor

Overview:
- Synthesizable successor to the pipeline bench's trace/log monitor.
- Sits beside the cpu and samples its WB-stage register write, MEM-stage load/store and halt every cycle.
- Keeps the cycle and instruction counters and serializes commit events into a parametrised trace FIFO drained by a valid/ready consumer (UART/debug port or bench).
- Adds what the bench lacked: multi-event-per-cycle ordering, bounded buffering with overflow accounting, capture enable, and an in-hardware cycle-limit watchdog.

Parameters:
DATA_W, 16, width of register/memory data
ADDR_W, 16, width of PC and memory address; also the address field of an entry
REG_W, 4, register index width (REG_W <= ADDR_W)
DEPTH, 16, FIFO entries; power of two, >= 4
MAX_CYCLES, 100000, watchdog limit in cycles
CNT_W, 32, width of cycle_count, inst_count, drop_count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
trace_en  in  1  capture enable
pc  in  ADDR_W  current PC
reg_we  in  1  register file write this cycle
reg_idx  in  REG_W  destination register
reg_data  in  DATA_W  write-back data
mem_re  in  1  load this cycle
mem_we  in  1  store this cycle
mem_addr  in  ADDR_W  memory address
mem_wdata  in  DATA_W  store data
mem_rdata  in  DATA_W  load data
hlt  in  1  halt reached MEM/WB
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_entry  out  2+ADDR_W+DATA_W  {type[1:0], addr, data}
cycle_count  out  CNT_W  cycles since reset
inst_count  out  CNT_W  committed instructions
drop_count  out  CNT_W  entries dropped
overflow  out  1  sticky: a drop occurred
halted  out  1  sticky: halt seen
timeout  out  1  sticky: watchdog fired
done  out  1  (halted|timeout) & FIFO empty

Behaviour:
- Reset (sampled on posedge clk while rst=1): FIFO emptied; all counters 0; overflow, halted, timeout, out_valid, done = 0. Reset mid-run discards buffered entries with no partial output.
- State machine: RUN -> HALTED on hlt; RUN -> TIMEOUT when cycle_count == MAX_CYCLES-1 at a clock edge without hlt. hlt wins when both occur in the same cycle. HALTED and TIMEOUT are left only by rst.
- In RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - inst_count increments by exactly 1 when hlt|reg_we|mem_we, even if several are set.
  - Counters are independent of trace_en.
- In HALTED/TIMEOUT: counters and all input capture frozen; FIFO still drains.
- Event capture in RUN with trace_en=1, up to 4 entries per cycle, enqueued in this fixed order:
  - REG type 00: addr = zero-extended reg_idx, data = reg_data.
  - LOAD type 01: addr = mem_addr, data = mem_rdata.
  - STORE type 10: addr = mem_addr, data = mem_wdata.
  - HALT type 11: addr = pc, data = 0.
- mem_re and mem_we set together: LOAD before STORE.
- Enqueue rule (all-or-nothing per cycle):
  - n = number of events; free = DEPTH - occupancy at start of cycle. A same-cycle pop is not credited.
  - If n <= free, all n are written.
  - Otherwise none are written, drop_count += n (saturating) and overflow is set.
  - A HALT entry is never dropped: on overflow only HALT is written if free >= 1.
  - halted is set regardless of whether the HALT entry was written.
- FIFO:
  - Head pops when out_valid & out_ready.
  - Occupancy next = occ + written - popped.
  - Pointers wrap modulo DEPTH.
  - out_entry is stable while out_valid & !out_ready.
- Latency: an event sampled at edge k appears at the head (if the FIFO was empty) with out_valid=1 after edge k, i.e. during cycle k+1.
- done: combinational from the registered sticky flags and the empty flag.

Test Plan:
- Reset then 3 cycles with reg_we=1, reg_idx=3, reg_data=0x00AB, out_ready=1 -> entries {00,0x0003,0x00AB} x3 in order; inst_count=3; cycle_count=3.
- Single cycle with reg_we, mem_re, mem_we, hlt all set (mem_addr=0x0040, mem_rdata=0x1111, mem_wdata=0x2222, pc=0x0010) -> 4 entries REG, LOAD, STORE, HALT in that order; inst_count +1; halted=1; done=1 after the 4th pop.
- out_ready=0, DEPTH=16, 16 reg writes, then a 17th reg write, then reg_we+mem_we in one cycle -> occupancy 16; drop_count=3; overflow=1; later drain yields exactly 16 entries.
- FIFO full (16) with hlt alone -> HALT dropped except when free>=1; with occupancy 15 plus reg_we+hlt -> only HALT written, drop_count +1.
- MAX_CYCLES=20, no hlt -> timeout=1 after 20 cycles; cycle_count frozen at 20; subsequent reg_we produces no entry and no inst_count change.
- rst asserted mid-drain with 5 entries queued -> next cycle out_valid=0; all counters 0; sticky flags cleared; trace_en=0 with reg_we toggling -> inst_count advances, no entries.
